axis_testpattern_checker: RTL

AXIS_TESTPATTERN_CHECKER -- requirements
Module: axis_testpattern_checker

---
 rtl/axis_testpattern_checker.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/axis_testpattern_checker.sv
// AXI-Stream test-pattern checker: locks onto a counting pattern and tallies beats/mismatches.
// Status outputs update one cycle after the accepting edge; tready is enable registered one clock.
module axis_testpattern_checker #(
  parameter int S00_AXIS_TDATA_WIDTH = 32,
  parameter int COUNTER_START        = 0,
  parameter int COUNTER_END          = 255,
  parameter int COUNTER_INCR         = 1,
  parameter int LOSS_THRESHOLD       = 4
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset,
  input  logic                            enable,
  input  logic                            clear_counts,
  input  logic [S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic                            locked,
  output logic                            error_pulse,
  output logic [31:0]                     beat_count,
  output logic [31:0]                     error_count,
  output logic [S00_AXIS_TDATA_WIDTH-1:0] expected
);

  localparam int W  = S00_AXIS_TDATA_WIDTH;
  localparam int RW = (LOSS_THRESHOLD < 2) ? 1 : $clog2(LOSS_THRESHOLD + 1);

  localparam logic [W-1:0] LP_ONE     = W'(1);
  localparam logic [W-1:0] LP_START   = W'(COUNTER_START);
  localparam logic [W-1:0] LP_END     = W'(COUNTER_END);
  localparam logic [W-1:0] LP_INCR    = W'(COUNTER_INCR);
  localparam logic [W-1:0] LP_SPAN    = LP_END - LP_START;
  localparam logic [W-1:0] LP_WRAP_AT = LP_END - LP_INCR + LP_ONE;
  localparam logic [W-1:0] LP_WRAP_DN = LP_SPAN + LP_ONE;
  localparam logic [RW-1:0] LP_THRESH = RW'(LOSS_THRESHOLD);

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_expected;
  logic [W-1:0]  w_expected_nxt;
  logic [RW-1:0] r_run;
  logic [RW-1:0] w_run_nxt;
  logic [RW-1:0] w_run_inc;
  logic [31:0]   r_beat_count;
  logic [31:0]   w_beat_count_nxt;
  logic [31:0]   r_error_count;
  logic [31:0]   w_error_count_nxt;
  logic          r_error_pulse;
  logic          w_mismatch;
  logic          r_tready;
  logic          r_rst_done;
  logic          w_accept;
  logic          w_in_range;

  // Wraps back into [START, END] once the step would run past END.
  function automatic logic [W-1:0] f_next(input logic [W-1:0] v);
    if (v >= LP_WRAP_AT) begin
      f_next = v + LP_INCR - LP_WRAP_DN;
    end else begin
      f_next = v + LP_INCR;
    end
  endfunction

  function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
    f_sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_accept   = s_axis_tvalid & r_tready;
  // Modular offset test keeps the range check free of always-true compares.
  assign w_in_range = ((s_axis_tdata - LP_START) <= LP_SPAN);
  assign w_run_inc  = r_run + RW'(1);

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_expected_nxt    = r_expected;
    w_run_nxt         = r_run;
    w_beat_count_nxt  = r_beat_count;
    w_error_count_nxt = r_error_count;
    w_mismatch        = 1'b0;

    if (w_accept) begin
      w_beat_count_nxt = f_sat_inc(r_beat_count);
      case (r_state)
        ST_SYNC: begin
          if (w_in_range) begin
            w_expected_nxt = f_next(s_axis_tdata);
            w_state_nxt    = ST_LOCKED;
          end else begin
            w_mismatch = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (s_axis_tdata == r_expected) begin
            w_expected_nxt = f_next(r_expected);
            w_run_nxt      = '0;
          end else begin
            w_mismatch     = 1'b1;
            w_expected_nxt = f_next(s_axis_tdata);
            if (w_run_inc >= LP_THRESH) begin
              w_state_nxt = ST_SYNC;
              w_run_nxt   = '0;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end
        end
        default: begin
          w_state_nxt = ST_SYNC;
        end
      endcase
      if (w_mismatch) begin
        w_error_count_nxt = f_sat_inc(r_error_count);
      end
    end

    // Clear beats any same-cycle count update; pattern tracking carries on.
    if (clear_counts) begin
      w_beat_count_nxt  = '0;
      w_error_count_nxt = '0;
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_expected    <= LP_START;
      r_run         <= '0;
      r_beat_count  <= '0;
      r_error_count <= '0;
      r_error_pulse <= 1'b0;
      r_rst_done    <= 1'b0;
      r_tready      <= 1'b0;
    end else begin
      r_expected    <= w_expected_nxt;
      r_run         <= w_run_nxt;
      r_beat_count  <= w_beat_count_nxt;
      r_error_count <= w_error_count_nxt;
      r_error_pulse <= w_mismatch;
      // One settling edge after reset release before ready can follow enable.
      r_rst_done    <= 1'b1;
      r_tready      <= enable & r_rst_done;
    end
  end

  assign s_axis_tready = r_tready;
  assign locked        = (r_state == ST_LOCKED);
  assign error_pulse   = r_error_pulse;
  assign beat_count    = r_beat_count;
  assign error_count   = r_error_count;
  assign expected      = r_expected;

endmodule
